pkt_rx_sink: RTL

PKT_RX_SINK -- requirements
Module: pkt_rx_sink

---
 rtl/pkt_rx_sink.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pkt_rx_sink.sv
// Receive end of a 4-phase Send/Ack link that buffers packets in a small first-word-fall-through FIFO.
// Optional macro PKT_RX_SYNC_EN adds a 2-flop synchronizer on Send_in for an asynchronous upstream.
module pkt_rx_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int PACKET_W   = 40
) (
    input  logic                          CP,
    input  logic                          MR,
    input  logic                          Send_in,
    input  logic [PACKET_W-1:0]           PACKET_IN,
    output logic                          Ack_out,
    output logic                          PKT_VALID,
    input  logic                          PKT_READY,
    output logic [PACKET_W-1:0]           PKT_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  s_send;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [PACKET_W-1:0]   mem [FIFO_DEPTH];

`ifdef PKT_RX_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge CP) begin
        if (MR) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], Send_in};
        end
    end

    assign s_send = sync_ff[1];
`else
    assign s_send = Send_in;
`endif

    // Full uses the occupancy from before the edge, so a same-edge pop cannot free a slot for a capture.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && PKT_READY;

    always_ff @(posedge CP) begin
        if (MR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (s_send && !full) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                if (!s_send) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Ack_out is a direct decode of the one-bit state flop, so it is glitch-free.
    always_comb begin
        Ack_out = (state == ACK);
        push    = (state == IDLE) && s_send && !full;
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (push && !MR) begin
            mem[wr_ptr] <= PACKET_IN;
        end
    end

    assign PKT_VALID = !empty;
    assign PKT_DATA  = mem[rd_ptr];
    assign COUNT     = count_q;

endmodule
